sha_k_sequencer: RTL and testbench

Parametrised round-constant sequencer: the next generation of the SHA-256 K lookup, covering both the SHA-256 (64 × 32-bit) and SHA-512 (80 × 64-bit) constant tables from FIPS 180-4. It owns its own round counter and streams one Kt per cycle with valid/last flags. It supports hold (stall), starting mid-schedule (midstate round skipping), and seamless looping for back-to-back compressions. It sits beside the compression core; the core no longer drives a round index into the constant store.

---
 rtl/sha_k_sequencer.sv | 140 ++++++++++++++
 tb/tb_sha_k_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_k_sequencer.sv
// Round-constant sequencer for SHA-256 (64 x 32-bit) and SHA-512 (80 x 64-bit).
// Owns the round counter and streams one registered K[round] per non-held cycle.
module sha_k_sequencer #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [6:0]            start_round,
  input  logic                  loop,
  input  logic                  hold,
  output logic [WORD_WIDTH-1:0] Kt,
  output logic [6:0]            round,
  output logic                  valid,
  output logic                  last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int         ROUNDS   = (WORD_WIDTH == 64) ? 80 : 64;
  localparam logic [6:0] N_RND    = 7'(ROUNDS);
  localparam logic [6:0] LAST_RND = 7'(ROUNDS - 1);

  generate
    if (WORD_WIDTH != 32 && WORD_WIDTH != 64) begin : g_bad_width
      $error("sha_k_sequencer: WORD_WIDTH must be 32 or 64");
    end
  endgenerate

  // SHA-256 K[i] is exactly the upper 32 bits of SHA-512 K[i] for i < 64.
  localparam logic [63:0] K512 [0:79] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  // Out-of-range addresses read as zero so Kt can never go X.
  function automatic logic [WORD_WIDTH-1:0] k_rom(input logic [6:0] idx);
    logic [63:0] w;
    w = '0;
    if (idx < N_RND) w = K512[idx];
    if (WORD_WIDTH == 32) w = {32'h0, w[63:32]};
    return w[WORD_WIDTH-1:0];
  endfunction

  typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;

  state_t                state_q, state_d;
  logic [6:0]            round_q, round_d;
  logic [WORD_WIDTH-1:0] kt_q, kt_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  rom_en;
  logic                  start_ok;

  // valid qualifies Kt/round for the consumer; there is no back-pressure other than hold.
  assign start_ok = start && (start_round < N_RND);

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = start && !start_ok;
    rom_en  = 1'b0;
    if (start_ok) begin
      state_d = S_RUN;
      round_d = start_round;
      valid_d = 1'b1;
      rom_en  = 1'b1;
    end else if (state_q == S_RUN && !hold) begin
      if (round_q != LAST_RND) begin
        round_d = round_q + 7'd1;
        rom_en  = 1'b1;
      end else if (loop) begin
        round_d = 7'd0;
        rom_en  = 1'b1;
      end else begin
        state_d = S_IDLE;
        round_d = 7'd0;
        valid_d = 1'b0;
        done_d  = 1'b1;
      end
    end
    // Single ROM read port, addressed by the next round value.
    if (rom_en)       kt_d = k_rom(round_d);
    else if (valid_d) kt_d = kt_q;
    else              kt_d = '0;
    last_d = valid_d && (round_d == LAST_RND);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      round_q <= '0;
      kt_q    <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      kt_q    <= kt_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign Kt    = kt_q;
  assign round = round_q;
  assign valid = valid_q;
  assign last  = last_q;
  assign busy  = (state_q == S_RUN);
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_sha_k_sequencer.sv
// Directed bench for sha_k_sequencer: vector table plus multi-cycle sequences,
// covering both the 32-bit and 64-bit constant tables.
module tb_sha_k_sequencer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic        start, loop, hold;
  logic [6:0]  start_round;
  logic [31:0] kt32;
  logic [6:0]  round32;
  logic        valid32, last32, busy32, done32, err32;

  logic        s64_start, s64_loop, s64_hold;
  logic [6:0]  s64_start_round;
  logic [63:0] kt64;
  logic [6:0]  round64;
  logic        valid64, last64, busy64, done64, err64;

  sha_k_sequencer #(.WORD_WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start), .start_round(start_round),
    .loop(loop), .hold(hold), .Kt(kt32), .round(round32), .valid(valid32),
    .last(last32), .busy(busy32), .done(done32), .err(err32)
  );

  sha_k_sequencer #(.WORD_WIDTH(64)) dut64 (
    .clk(clk), .reset(reset), .start(s64_start), .start_round(s64_start_round),
    .loop(s64_loop), .hold(s64_hold), .Kt(kt64), .round(round64), .valid(valid64),
    .last(last64), .busy(busy64), .done(done64), .err(err64)
  );

  // ---------------- scoreboard state ----------------
  int         n_cmp = 0;
  int         n_fail = 0;
  int         valid_cnt = 0;
  logic [6:0] exp_q[$];

  typedef struct {
    logic        st;
    logic [6:0]  sr;
    logic        lp;
    logic        hd;
    logic [6:0]  e_round;
    logic [31:0] e_kt;
    logic        e_valid;
    logic        e_last;
    logic        e_busy;
    logic        e_done;
    logic        e_err;
  } vec_t;

  vec_t vecs[16];

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    if (valid32) valid_cnt++;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic wait_round32(input logic [6:0] r, input string name);
    for (int i = 0; i < 200 && !(valid32 && round32 == r); i++) tick;
    check(name, {63'd0, (valid32 && round32 == r)}, 64'd1);
  endtask

  task automatic wait_done32(input string name);
    for (int i = 0; i < 200 && !done32; i++) tick;
    check(name, {63'd0, done32}, 64'd1);
  endtask

  task automatic fill_exp(input int lo, input int hi);
    for (int r = lo; r <= hi; r++) exp_q.push_back(7'(r));
  endtask

  task automatic check_sb(input string name);
    if (exp_q.size() > 0) begin
      check(name, {57'd0, round32}, {57'd0, exp_q.pop_front()});
    end else begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got unexpected round %0d, expected no more valid", name, round32);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test body ----------------
  initial begin
    logic       prev_last;
    logic       wrapped;
    logic [6:0] prev_round;
    int         n_done;
    int         nv64;

    // {st, sr, lp, hd, round, Kt, valid, last, busy, done, err}
    vecs[0]  = '{1'b1, 7'd60,  1'b0, 1'b0, 7'd60, 32'h90befffa, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 7'd0,   1'b0, 1'b0, 7'd61, 32'ha4506ceb, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 7'd0,   1'b0, 1'b1, 7'd61, 32'ha4506ceb, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 7'd0,   1'b0, 1'b0, 7'd62, 32'hbef9a3f7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 7'd0,   1'b0, 1'b0, 7'd63, 32'hc67178f2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 7'd0,   1'b0, 1'b0, 7'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 7'd0,   1'b0, 1'b0, 7'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 7'd64,  1'b0, 1'b0, 7'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 7'd0,   1'b0, 1'b0, 7'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 7'd62,  1'b1, 1'b0, 7'd62, 32'hbef9a3f7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 7'd0,   1'b1, 1'b0, 7'd63, 32'hc67178f2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 7'd0,   1'b1, 1'b1, 7'd63, 32'hc67178f2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 7'd0,   1'b1, 1'b0, 7'd0,  32'h428a2f98, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 7'd70,  1'b0, 1'b0, 7'd1,  32'h71374491, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 7'd5,   1'b0, 1'b0, 7'd5,  32'h59f111f1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 7'd127, 1'b0, 1'b1, 7'd5,  32'h59f111f1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    reset = 1'b1;
    start = 1'b0; start_round = '0; loop = 1'b0; hold = 1'b0;
    s64_start = 1'b0; s64_start_round = '0; s64_loop = 1'b0; s64_hold = 1'b0;
    tick;
    check("rst_kt32", {32'd0, kt32}, 64'd0);
    check("rst_round32", {57'd0, round32}, 64'd0);
    check("rst_flags32", {57'd0, valid32, last32, busy32, done32, err32}, 64'd0);
    check("rst_kt64", kt64, 64'd0);
    check("rst_flags64", {57'd0, valid64, last64, busy64, done64, err64}, 64'd0);
    tick;
    reset = 1'b0;

    // vector table
    foreach (vecs[i]) begin
      start = vecs[i].st; start_round = vecs[i].sr; loop = vecs[i].lp; hold = vecs[i].hd;
      tick;
      if (vecs[i].e_valid) begin
        check($sformatf("vec%0d_round", i), {57'd0, round32}, {57'd0, vecs[i].e_round});
        check($sformatf("vec%0d_kt", i), {32'd0, kt32}, {32'd0, vecs[i].e_kt});
      end
      check($sformatf("vec%0d_flags", i), {59'd0, valid32, last32, busy32, done32, err32},
            {59'd0, vecs[i].e_valid, vecs[i].e_last, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_err});
    end
    start = 1'b0; loop = 1'b0; hold = 1'b0;
    do_reset;

    // full 32-bit schedule from round 0
    exp_q.delete();
    fill_exp(0, 63);
    valid_cnt = 0; n_done = 0; prev_last = 1'b0;
    start = 1'b1; start_round = 7'd0;
    tick;
    start = 1'b0;
    for (int c = 0; c < 70; c++) begin
      if (valid32) begin
        check_sb("full_round");
        check("full_last", {63'd0, last32}, {63'd0, (round32 == 7'd63)});
        if (round32 == 7'd0)  check("full_kt0", {32'd0, kt32}, 64'h428a2f98);
        if (round32 == 7'd63) check("full_kt63", {32'd0, kt32}, 64'hc67178f2);
      end
      if (done32) begin
        n_done++;
        check("full_done_after_last", {63'd0, prev_last}, 64'd1);
        check("full_done_idle", {62'd0, valid32, busy32}, 64'd0);
      end
      prev_last = last32;
      tick;
    end
    check("full_valid_cnt", 64'(valid_cnt), 64'd64);
    check("full_done_cnt", 64'(n_done), 64'd1);
    check("full_q_empty", 64'(exp_q.size()), 64'd0);
    check("full_end_busy", {62'd0, busy32, done32}, 64'd0);

    // hold at round 10 for three cycles
    valid_cnt = 0;
    start = 1'b1; start_round = 7'd0;
    tick;
    start = 1'b0;
    wait_round32(7'd10, "hold_reach10");
    check("hold_kt10", {32'd0, kt32}, 64'h243185be);
    hold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      tick;
      check("hold_round", {57'd0, round32}, 64'd10);
      check("hold_kt", {32'd0, kt32}, 64'h243185be);
    end
    hold = 1'b0;
    tick;
    check("hold_next_round", {57'd0, round32}, 64'd11);
    check("hold_next_kt", {32'd0, kt32}, 64'h550c7dc3);
    wait_done32("hold_done");
    check("hold_valid_cnt", 64'(valid_cnt), 64'd67);

    // looping: rounds 3..63 then 0..63
    exp_q.delete();
    fill_exp(3, 63);
    fill_exp(0, 63);
    valid_cnt = 0; wrapped = 1'b0; prev_round = '0;
    start = 1'b1; start_round = 7'd3; loop = 1'b1;
    tick;
    start = 1'b0;
    for (int c = 0; c < 300 && !done32; c++) begin
      check("loop_valid_cont", {63'd0, valid32}, 64'd1);
      if (valid32) check_sb("loop_round");
      if (valid32 && round32 == 7'd0 && !wrapped) begin
        wrapped = 1'b1;
        check("loop_wrap_kt", {32'd0, kt32}, 64'h428a2f98);
        check("loop_wrap_prev", {57'd0, prev_round}, 64'd63);
      end
      if (wrapped && round32 == 7'd10) loop = 1'b0;
      prev_round = round32;
      tick;
    end
    check("loop_done", {63'd0, done32}, 64'd1);
    check("loop_wrapped", {63'd0, wrapped}, 64'd1);
    check("loop_last_prev", {57'd0, prev_round}, 64'd63);
    check("loop_q_empty", 64'(exp_q.size()), 64'd0);
    check("loop_valid_cnt", 64'(valid_cnt), 64'd125);
    loop = 1'b0;

    // mid-run restart, rejected start, async reset
    start = 1'b1; start_round = 7'd0;
    tick;
    start = 1'b0;
    wait_round32(7'd40, "mid_reach40");
    start = 1'b1; start_round = 7'd5;
    tick;
    start = 1'b0;
    check("restart_round", {57'd0, round32}, 64'd5);
    check("restart_kt", {32'd0, kt32}, 64'h59f111f1);
    check("restart_nodone", {62'd0, done32, valid32}, 64'd1);
    start = 1'b1; start_round = 7'd64;
    tick;
    start = 1'b0;
    check("badstart_err", {63'd0, err32}, 64'd1);
    check("badstart_round", {57'd0, round32}, 64'd6);
    check("badstart_kt", {32'd0, kt32}, 64'h923f82a4);
    tick;
    check("badstart_err_clr", {63'd0, err32}, 64'd0);
    check("badstart_next", {57'd0, round32}, 64'd7);
    wait_round32(7'd20, "mid_reach20");
    reset = 1'b1;
    #1;
    check("async_rst_kt", {32'd0, kt32}, 64'd0);
    check("async_rst_round", {57'd0, round32}, 64'd0);
    check("async_rst_flags", {59'd0, valid32, last32, busy32, done32, err32}, 64'd0);
    tick;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick;
      check("post_rst_quiet", {61'd0, done32, busy32, valid32}, 64'd0);
    end
    start = 1'b1; start_round = 7'd7;
    tick;
    start = 1'b0;
    check("post_rst_start", {57'd0, round32}, 64'd7);
    check("post_rst_kt", {32'd0, kt32}, 64'hab1c5ed5);
    do_reset;

    // 64-bit table
    nv64 = 0;
    s64_start = 1'b1; s64_start_round = 7'd0;
    tick;
    s64_start = 1'b0;
    for (int c = 0; c < 90; c++) begin
      if (valid64) begin
        nv64++;
        if (round64 == 7'd0)  check("w64_kt0", kt64, 64'h428a2f98d728ae22);
        if (round64 == 7'd10) check("w64_kt10", kt64, 64'h243185be4ee4b28c);
        if (round64 == 7'd79) check("w64_kt79", kt64, 64'h6c44198c4a475817);
        check("w64_last", {63'd0, last64}, {63'd0, (round64 == 7'd79)});
      end
      tick;
    end
    check("w64_valid_cnt", 64'(nv64), 64'd80);
    check("w64_idle", {63'd0, busy64}, 64'd0);
    s64_start = 1'b1; s64_start_round = 7'd80;
    tick;
    s64_start = 1'b0;
    check("w64_err", {62'd0, err64, busy64}, 64'd2);
    tick;
    check("w64_err_clr", {63'd0, err64}, 64'd0);
    s64_start = 1'b1; s64_start_round = 7'd79;
    tick;
    s64_start = 1'b0;
    check("w64_start79", {62'd0, valid64, last64}, 64'd3);
    check("w64_start79_kt", kt64, 64'h6c44198c4a475817);
    tick;
    check("w64_done", {63'd0, done64}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
